// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Accepts one command at a time on a valid/ready port, runs the SETUP/ACCESS
// handshake on the APB side, and returns a one-cycle completion pulse with
// read data and error status. A bounded wait counter aborts transfers whose
// slave never raises PREADY.
module apb_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command side
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    // completion side
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // APB requester side
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // TIMEOUT is limited to 1..255, so an 8-bit counter always holds it.
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        wait_cnt_reg;
    logic [7:0]        wait_cnt_next;

    logic              accept;
    logic              xfer_done;
    logic              xfer_timeout;

    logic [ADDR_W-1:0] paddr_reg;
    logic              pwrite_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic              rsp_valid_reg;
    logic [DATA_W-1:0] rsp_rdata_reg;
    logic              rsp_err_reg;

    // Handshake decode, ready generation and next-state / wait-counter logic.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        // A ready slave wins over an expiring counter in the same cycle.
        xfer_done    = (state_reg == ACCESS) && PREADY;
        xfer_timeout = (state_reg == ACCESS) && !PREADY && (wait_cnt_reg == TIMEOUT_CNT);

        // New work is taken while idle, or in the completing ACCESS cycle so
        // back-to-back transfers lose no bus cycle. Never on a timeout cycle.
        req_ready = (state_reg == IDLE) || xfer_done;
        accept    = req_valid && req_ready;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                wait_cnt_next = 8'd0;
            end
            ACCESS: begin
                if (xfer_done) begin
                    state_next = accept ? SETUP : IDLE;
                end else if (xfer_timeout) begin
                    state_next = IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and wait counter.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // Registered APB control/address/data outputs, tracking the next state.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            psel_reg    <= 1'b0;
            penable_reg <= 1'b0;
            paddr_reg   <= '0;
            pwrite_reg  <= 1'b0;
            pwdata_reg  <= '0;
        end else begin
            psel_reg    <= (state_next != IDLE);
            penable_reg <= (state_next == ACCESS);
            // Address/data only move on accept, so they stay put through
            // SETUP and every ACCESS cycle of the transfer.
            if (accept) begin
                paddr_reg  <= req_addr;
                pwrite_reg <= req_write;
                pwdata_reg <= req_wdata;
            end
        end
    end

    // Completion pulse; slave data and status are looked at only when PREADY ends ACCESS.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= xfer_done || xfer_timeout;
            rsp_err_reg   <= xfer_done ? PSLVERR : xfer_timeout;
            if (xfer_done && !pwrite_reg && !PSLVERR) begin
                rsp_rdata_reg <= PRDATA;
            end else begin
                rsp_rdata_reg <= '0;
            end
        end
    end

    assign PADDR     = paddr_reg;
    assign PWRITE    = pwrite_reg;
    assign PSEL      = psel_reg;
    assign PENABLE   = penable_reg;
    assign PWDATA    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed + randomized bench for apb_master with a planned
// APB slave and a transaction-level reference model of the responses.
module tb_apb_master;

    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic              PSEL;
    logic              PENABLE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- per-transfer plan (slave behaviour + intent) --------
    int                plan_wait  [256];
    bit                plan_err   [256];
    logic [ADDR_W-1:0] plan_addr  [256];
    bit                plan_write [256];
    logic [DATA_W-1:0] plan_wdata [256];
    int                n_issued = 0;

    // ---------------- reference model ------------------------------------
    typedef struct {
        int                edge_n;
        logic              err;
        logic [DATA_W-1:0] rdata;
        bit                tmo;
    } exp_t;
    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [16];
    int                n_rsp = 0;

    // ---------------- slave model -----------------------------------------
    logic [DATA_W-1:0] slv_mem [16];
    int                cur_idx = -1;
    int                acc_cnt = 0;
    logic [DATA_W-1:0] junk_data;
    logic              junk_bit;
    int                edge_cnt = 0;

    always @(posedge PCLK) edge_cnt <= edge_cnt + 1;

    // Slave: ready once its planned number of wait cycles has elapsed; garbage otherwise.
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = junk_bit;
        PRDATA  = junk_data;
        if (PSEL && PENABLE && cur_idx >= 0 && acc_cnt >= plan_wait[cur_idx]) begin
            PREADY  = 1'b1;
            PSLVERR = plan_err[cur_idx];
            PRDATA  = plan_err[cur_idx] ? 32'h1234_5678 : slv_mem[PADDR];
        end
    end

    // Slave sequential state: transfer index, wait counting, register writes.
    always @(posedge PCLK) begin
        junk_data <= $urandom;
        junk_bit  <= 1'($urandom_range(0, 1));
        if (!PRESET && PSEL && !PENABLE) cur_idx <= cur_idx + 1;
        if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (!PRESET && PSEL && PENABLE && PREADY && PWRITE && !PSLVERR)
            slv_mem[PADDR] <= PWDATA;
    end

    // ---------------- monitors --------------------------------------------
    logic [5:0]                 pen_hist = '0;
    logic [5:0]                 sel_hist = '0;
    logic [ADDR_W+DATA_W:0]     held = '0;

    always @(negedge PCLK) begin
        pen_hist <= {pen_hist[4:0], PENABLE};
        sel_hist <= {sel_hist[4:0], PSEL};
    end

    // Response checker: compares each completion with the model queue.
    always @(negedge PCLK) begin
        exp_t e;
        if (!PRESET) begin
            if (!rsp_valid && exp_q.size() > 0 && exp_q[0].edge_n <= edge_cnt + 1) begin
                check_eq("rsp_missing", 64'(rsp_valid), 64'(1));
                void'(exp_q.pop_front());
            end else if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("rsp_spurious", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_edge",  64'(edge_cnt + 1), 64'(e.edge_n));
                    check_eq("rsp_err",   64'(rsp_err),      64'(e.err));
                    check_eq("rsp_rdata", 64'(rsp_rdata),    64'(e.rdata));
                    if (e.tmo) check_eq("bus_idle_after_timeout", 64'({PSEL, PENABLE}), 64'(0));
                    $display("rsp %0d edge=%0d err=%0b rdata=0x%08h tmo=%0b",
                             n_rsp, edge_cnt + 1, rsp_err, rsp_rdata, e.tmo);
                    n_rsp++;
                end
            end
        end
    end

    // Bus checker: SETUP carries the planned command; ACCESS holds it unchanged.
    always @(negedge PCLK) begin
        if (!PRESET && PSEL) begin
            if (!PENABLE) begin
                check_eq("paddr_setup",  64'(PADDR),  64'(plan_addr[cur_idx + 1]));
                check_eq("pwrite_setup", 64'(PWRITE), 64'(plan_write[cur_idx + 1]));
                if (plan_write[cur_idx + 1])
                    check_eq("pwdata_setup", 64'(PWDATA), 64'(plan_wdata[cur_idx + 1]));
                held <= {PADDR, PWRITE, PWDATA};
            end else begin
                check_eq("bus_hold", 64'({PADDR, PWRITE, PWDATA}), 64'(held));
            end
        end
    end

    // ---------------- driver ----------------------------------------------
    task automatic do_req(input logic [ADDR_W-1:0] a, input bit w, input logic [DATA_W-1:0] d,
                          input int wt, input bit er, input bit exp_rsp);
        int   idx;
        int   n;
        int   w_eff;
        exp_t e;
        idx = n_issued;
        n_issued++;
        plan_wait[idx]  = wt;
        plan_err[idx]   = er;
        plan_addr[idx]  = a;
        plan_write[idx] = w;
        plan_wdata[idx] = d;
        @(negedge PCLK);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
        n = 0;
        #1;
        while (!req_ready) begin
            if (n > 60) begin
                check_eq("req_accept_wait", 64'(req_ready), 64'(1));
                req_valid = 1'b0;
                return;
            end
            @(negedge PCLK);
            #1;
            n++;
        end
        @(posedge PCLK);
        #1;
        if (exp_rsp) begin
            // Model: completion W+3 edges after accept; waits beyond TIMEOUT abort.
            e.tmo    = (wt > TIMEOUT);
            w_eff    = e.tmo ? TIMEOUT : wt;
            e.edge_n = edge_cnt + 3 + w_eff;
            if (e.tmo || er) begin
                e.err   = 1'b1;
                e.rdata = '0;
            end else if (w) begin
                e.err      = 1'b0;
                e.rdata    = '0;
                ref_mem[a] = d;
            end else begin
                e.err   = 1'b0;
                e.rdata = ref_mem[a];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            req_valid = 1'b0;
        end
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        int wt;
        int n;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        PRESET    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        repeat (3) @(negedge PCLK);
        #1;
        check_eq("rst_psel",      64'(PSEL),      64'(0));
        check_eq("rst_penable",   64'(PENABLE),   64'(0));
        check_eq("rst_pwrite",    64'(PWRITE),    64'(0));
        check_eq("rst_paddr",     64'(PADDR),     64'(0));
        check_eq("rst_pwdata",    64'(PWDATA),    64'(0));
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check_eq("rst_rsp_err",   64'(rsp_err),   64'(0));
        PRESET = 1'b0;
        @(negedge PCLK);
        #1;
        check_eq("idle_req_ready", 64'(req_ready), 64'(1));

        // Write with one wait state, then read it back.
        do_req(4'h4, 1'b1, 32'hDEAD_BEEF, 1, 1'b0, 1'b1);
        idle(6);
        check_eq("slave_reg1", 64'(slv_mem[4]), 64'(32'hDEAD_BEEF));
        do_req(4'h4, 1'b0, $urandom, 2, 1'b0, 1'b1);
        idle(8);

        // Back-to-back writes with req_valid held.
        do_req(4'h0, 1'b1, $urandom, 1, 1'b0, 1'b1);
        do_req(4'h8, 1'b1, $urandom, 1, 1'b0, 1'b1);
        @(negedge PCLK);
        req_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        check_eq("b2b_psel",    64'(sel_hist), 64'(6'b111111));
        check_eq("b2b_penable", 64'(pen_hist), 64'(6'b011011));
        idle(6);

        // Timeout, then the W == TIMEOUT boundary, then a normal transfer.
        do_req(4'h2, 1'b0, $urandom, 10, 1'b0, 1'b1);
        idle(4);
        do_req(4'h2, 1'b1, 32'hA5A5_0002, TIMEOUT, 1'b0, 1'b1);
        do_req(4'h2, 1'b0, $urandom, 0, 1'b0, 1'b1);
        idle(6);

        // Slave error on a read.
        do_req(4'h5, 1'b0, $urandom, 0, 1'b1, 1'b1);
        idle(5);

        // Reset while in ACCESS: transfer dropped silently.
        do_req(4'h6, 1'b1, 32'h0BAD_0BAD, 3, 1'b0, 1'b0);
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check_eq("mid_rst_psel",      64'(PSEL),      64'(0));
        check_eq("mid_rst_penable",   64'(PENABLE),   64'(0));
        check_eq("mid_rst_req_ready", 64'(req_ready), 64'(1));
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("mid_rst_paddr",     64'(PADDR),     64'(0));
        idle(10);
        check_eq("mid_rst_no_write", 64'(slv_mem[6]), 64'(0));

        // Randomized traffic, including back-to-back and timeouts.
        for (int i = 0; i < 60; i++) begin
            wt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 8)) : int'($urandom_range(0, 4));
            do_req(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom, wt,
                   ($urandom_range(0, 7) == 0), 1'b1);
            idle(int'($urandom_range(0, 2)));
        end
        idle(1);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge PCLK);
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'(0));
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 4, APB address width in bits.
REQ-002 Parameter DATA_W, default 32, APB data width in bits.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS cycles with PREADY low before the transfer is aborted; legal range 1..255.
REQ-004 PCLK  in  1  single clock; all logic on the rising edge.
REQ-005 PRESET  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  1  command request.
REQ-007 req_ready  out  1  command accepted when req_valid and req_ready are both high at a PCLK edge.
REQ-008 req_addr  in  ADDR_W  command address.
REQ-009 req_write  in  1  1 = write, 0 = read.
REQ-010 req_wdata  in  DATA_W  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse.
REQ-012 rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
REQ-013 rsp_err  out  1  completion status; 1 = PSLVERR or timeout.
REQ-014 PADDR  out  ADDR_W; PWRITE  out  1; PSEL  out  1; PENABLE  out  1; PWDATA  out  DATA_W.
REQ-015 PRDATA  in  DATA_W; PREADY  in  1; PSLVERR  in  1 (tie to 0 for slaves that do not drive it).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-017 PSEL, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata and rsp_err SHALL be registered outputs.
REQ-018 req_ready SHALL be combinational: 1 in IDLE; 1 in ACCESS while PREADY=1; 0 otherwise, including in ACCESS on a timeout cycle.
REQ-019 IDLE: PSEL=0, PENABLE=0. On accept, the block SHALL latch addr, write and wdata onto PADDR, PWRITE and PWDATA, then go to SETUP.
REQ-020 SETUP (exactly one cycle): PSEL=1, PENABLE=0. The block SHALL then go unconditionally to ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1. PADDR, PWRITE and PWDATA SHALL be held stable from SETUP to the end of ACCESS.
REQ-022 ACCESS with PREADY=1 sampled completes the transfer. On the next cycle the block SHALL drive:
  - rsp_valid=1
  - rsp_err=PSLVERR
  - rsp_rdata=PRDATA, only if read and PSLVERR=0; else 0.
REQ-023 After completion, the next state SHALL be SETUP if a new request is accepted in the same cycle (back-to-back, PENABLE drops to 0 for one cycle), else IDLE with PSEL=0.
REQ-024 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-025 When the counter reaches TIMEOUT with PREADY still 0, the block SHALL abort:
  - next cycle PSEL=0, PENABLE=0, state IDLE
  - rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-026 PREADY=1 in the same cycle the counter reaches TIMEOUT SHALL count as normal completion, not a timeout.
REQ-027 Latency from accept edge to the rsp_valid edge SHALL be 3 + W cycles, where W is the number of wait cycles (PREADY low in ACCESS).
REQ-028 rsp_valid SHALL be a single-cycle pulse with no backpressure; rsp_rdata and rsp_err are valid only while rsp_valid=1.
REQ-029 req_* inputs SHALL be ignored when req_ready=0; only one transfer is outstanding at a time.
REQ-030 PRDATA and PSLVERR SHALL be sampled only in ACCESS with PREADY=1.

Reset
REQ-031 While PRESET=1 at a PCLK edge, the block SHALL:
  - set state to IDLE
  - drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0
  - drive rsp_valid=0, rsp_rdata=0, rsp_err=0
  - clear the wait counter.
REQ-032 Reset during SETUP or ACCESS SHALL drop the transfer silently with no rsp_valid, and req_ready SHALL be 1 on the first cycle after reset.

Verification
REQ-033 Write 0xDEADBEEF to addr 0x4; slave inserts 1 wait state -> SETUP 1 cycle, ACCESS 2 cycles; rsp_valid on cycle 4 after accept with rsp_err=0, rsp_rdata=0; slave reg1=0xDEADBEEF.
REQ-034 Read addr 0x4 after that write -> rsp_rdata=0xDEADBEEF, rsp_err=0; PADDR stable across SETUP and ACCESS.
REQ-035 Back-to-back: req_valid held with writes to 0x0 then 0x8 -> PSEL stays 1 throughout; PENABLE pattern 0,1,1,0,1,1; two rsp_valid pulses.
REQ-036 TIMEOUT=4 with PREADY tied 0 -> abort after 4 wait cycles; PSEL falls; rsp_valid=1, rsp_err=1, rsp_rdata=0; next request proceeds normally.
REQ-037 PSLVERR=1 with PREADY=1 on a read returning 0x12345678 -> rsp_err=1, rsp_rdata=0.
REQ-038 PRESET asserted in the ACCESS cycle -> next cycle PSEL=0, PENABLE=0, req_ready=1; no rsp_valid for the aborted transfer.
